// File: rtl/led_code_sched.sv
// Round-robin scheduler sharing one LED between NUM_REQ blink-code requesters.
// Optional idle heartbeat on the LED is enabled with `define LED_HEARTBEAT_EN.
module led_code_sched #(
    parameter int OSC_CLOCK = 27000000,
    parameter int TICK_HZ   = 10,
    parameter int NUM_REQ   = 4,
    parameter int CODE_W    = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3,
    parameter int GAP_TICKS = 10,
    parameter int HB_TICKS  = 5
) (
    input  logic                       in_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CODE_W-1:0]  code,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       done,
    output logic                       led
);

    localparam int TICK_DIV = OSC_CLOCK / TICK_HZ;
    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                led_reg, led_next;
    logic [23:0]         presc_reg, presc_next;
    logic [7:0]          phase_reg, phase_next;
    logic [CODE_W-1:0]   blink_reg, blink_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
`ifdef LED_HEARTBEAT_EN
    logic [7:0]          hb_reg, hb_next;
`endif

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PTR_W-1:0]    sel_idx;
    logic [PTR_W-1:0]    cand;
    logic                tick;
    logic [CODE_W-1:0]   blink_dec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = req[gi] && (code[gi*CODE_W +: CODE_W] != '0);
        end
    endgenerate

    assign tick      = (presc_reg == TICK_LAST);
    assign blink_dec = blink_reg - CODE_W'(1);

    // Round-robin search beginning just after the last owner.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        led_next    = led_reg;
        presc_next  = tick ? 24'd0 : presc_reg + 24'd1;
        phase_next  = phase_reg;
        blink_next  = blink_reg;
        rr_ptr_next = rr_ptr_reg;
`ifdef LED_HEARTBEAT_EN
        hb_next     = hb_reg;
`endif
        case (state_reg)
            S_IDLE: begin
`ifdef LED_HEARTBEAT_EN
                if (tick) begin
                    if (hb_reg == 8'(HB_TICKS - 1)) begin
                        hb_next  = 8'd0;
                        led_next = ~led_reg;
                    end else begin
                        hb_next = hb_reg + 8'd1;
                    end
                end
`else
                presc_next = 24'd0;
                led_next   = 1'b0;
`endif
                if (found) begin
                    state_next          = S_ON;
                    grant_next          = '0;
                    grant_next[sel_idx] = 1'b1;
                    busy_next           = 1'b1;
                    led_next            = 1'b1;
                    blink_next          = code[sel_idx*CODE_W +: CODE_W];
                    rr_ptr_next         = sel_idx;
                    presc_next          = 24'd0;
                    phase_next          = 8'd0;
`ifdef LED_HEARTBEAT_EN
                    hb_next             = 8'd0;
`endif
                end
            end
            S_ON: begin
                led_next = 1'b1;
                if (tick) begin
                    if (phase_reg == 8'(ON_TICKS - 1)) begin
                        phase_next = 8'd0;
                        blink_next = blink_dec;
                        led_next   = 1'b0;
                        state_next = (blink_dec == '0) ? S_GAP : S_OFF;
                    end else begin
                        phase_next = phase_reg + 8'd1;
                    end
                end
            end
            S_OFF: begin
                led_next = 1'b0;
                if (tick) begin
                    if (phase_reg == 8'(OFF_TICKS - 1)) begin
                        phase_next = 8'd0;
                        state_next = S_ON;
                        led_next   = 1'b1;
                    end else begin
                        phase_next = phase_reg + 8'd1;
                    end
                end
            end
            S_GAP: begin
                led_next = 1'b0;
                if (tick) begin
                    if (phase_reg == 8'(GAP_TICKS - 1)) begin
                        phase_next = 8'd0;
                        state_next = S_IDLE;
                        grant_next = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
`ifdef LED_HEARTBEAT_EN
                        hb_next    = 8'd0;
`endif
                    end else begin
                        phase_next = phase_reg + 8'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            grant_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            led_reg    <= 1'b0;
            presc_reg  <= 24'd0;
            phase_reg  <= 8'd0;
            blink_reg  <= '0;
            rr_ptr_reg <= PTR_W'(NUM_REQ - 1);
`ifdef LED_HEARTBEAT_EN
            hb_reg     <= 8'd0;
`endif
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            led_reg    <= led_next;
            presc_reg  <= presc_next;
            phase_reg  <= phase_next;
            blink_reg  <= blink_next;
            rr_ptr_reg <= rr_ptr_next;
`ifdef LED_HEARTBEAT_EN
            hb_reg     <= hb_next;
`endif
        end
    end

    assign grant = grant_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign led   = led_reg;

endmodule

// File: tb/tb_led_code_sched.sv
// Directed bench for led_code_sched: TICK_DIV=10, four requesters, ON/OFF/GAP = 2/3/10 ticks.
module tb_led_code_sched;

    logic        in_clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic        led;

    int passed_cnt = 0;
    int total_cnt  = 0;

    led_code_sched #(
        .OSC_CLOCK(100), .TICK_HZ(10), .NUM_REQ(4), .CODE_W(4),
        .ON_TICKS(2), .OFF_TICKS(3), .GAP_TICKS(10), .HB_TICKS(5)
    ) dut (
        .in_clk(in_clk), .reset(reset), .req(req), .code(code),
        .grant(grant), .busy(busy), .done(done), .led(led)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Follows a sequence from its grant cycle to the first IDLE cycle, logging LED run lengths.
    task automatic collect(output int total, output int nruns, output int runs[8]);
        logic prev;
        total = 0;
        nruns = 0;
        prev  = 1'bx;
        for (int i = 0; i < 8; i++) runs[i] = 0;
        while (busy === 1'b1 && total < 5000) begin
            if (led !== prev) nruns++;
            if (nruns >= 1 && nruns <= 8) runs[nruns-1]++;
            prev = led;
            total++;
            step();
        end
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (led === lvl && n < 300) begin
            n++;
            step();
        end
    endtask

    int tot, nr, n;
    int runs[8];
    logic [3:0] exp_g[5];

    initial begin
        reset = 1'b1;
        req   = '0;
        code  = '0;
        repeat (3) @(posedge in_clk);
        #1;
        reset = 1'b0;
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_led", 32'(led), 0);

        // Single request, code 3
        req  = 4'b0001;
        code = 16'h0003;
        step();
        chk("t1_grant", 32'(grant), 4'b0001);
        chk("t1_busy", 32'(busy), 1);
        req = 4'b0000;
        collect(tot, nr, runs);
        chk("t1_total", 32'(tot), 220);
        chk("t1_nruns", 32'(nr), 6);
        chk("t1_on1", 32'(runs[0]), 20);
        chk("t1_off1", 32'(runs[1]), 30);
        chk("t1_on2", 32'(runs[2]), 20);
        chk("t1_off2", 32'(runs[3]), 30);
        chk("t1_on3", 32'(runs[4]), 20);
        chk("t1_gap", 32'(runs[5]), 100);
        chk("t1_done", 32'(done), 1);
        chk("t1_idle_grant", 32'(grant), 0);
        step();
        chk("t1_done_pulse", 32'(done), 0);

        // Round-robin with all four requesting code 1
        do_reset();
        req  = 4'b1111;
        code = 16'h1111;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        step();
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rr_grant%0d", g), 32'(grant), 32'(exp_g[g]));
            collect(tot, nr, runs);
            chk($sformatf("rr_total%0d", g), 32'(tot), 120);
            chk($sformatf("rr_done%0d", g), 32'(done), 1);
            if (g == 4) req = 4'b0000;
            step();
        end
        chk("rr_final_grant", 32'(grant), 0);
        chk("rr_final_done", 32'(done), 0);

        // Zero code is never granted
        do_reset();
        req  = 4'b0011;
        code = 16'h0020;
        step();
        chk("zc_grant", 32'(grant), 4'b0010);
        collect(tot, nr, runs);
        chk("zc_total", 32'(tot), 170);
        chk("zc_done", 32'(done), 1);
        step();
        chk("zc_regrant", 32'(grant), 4'b0010);
        req = 4'b0000;
        collect(tot, nr, runs);
        chk("zc_total2", 32'(tot), 170);
        step();

        // Request dropped and code changed mid-sequence
        req  = 4'b0001;
        code = 16'h0002;
        step();
        chk("drop_grant", 32'(grant), 4'b0001);
        repeat (15) step();
        req  = 4'b0000;
        code = 16'h000F;
        collect(tot, nr, runs);
        chk("drop_total", 32'(tot + 15), 170);
        chk("drop_first_run", 32'(runs[0]), 5);
        chk("drop_done", 32'(done), 1);
        step();
        chk("drop_no_regrant", 32'(grant), 0);

        // Reset during OFF aborts with no done; pointer restarts at requester 0
        req  = 4'b0010;
        code = 16'h0030;
        step();
        chk("rst_grant", 32'(grant), 4'b0010);
        repeat (25) step();
        chk("rst_in_off_led", 32'(led), 0);
        chk("rst_in_off_busy", 32'(busy), 1);
        req = 4'b0000;
        do_reset();
        chk("rst_grant_clr", 32'(grant), 0);
        chk("rst_busy_clr", 32'(busy), 0);
        chk("rst_led_clr", 32'(led), 0);
        chk("rst_no_done", 32'(done), 0);
        req  = 4'b0110;
        code = 16'h0110;
        step();
        chk("rst_rr_restart", 32'(grant), 4'b0010);
        req = 4'b0000;
        collect(tot, nr, runs);
        chk("rst_seq_total", 32'(tot), 120);
        chk("rst_seq_done", 32'(done), 1);
        step();

`ifdef LED_HEARTBEAT_EN
        // Idle heartbeat, interrupted by a sequence and restarted afterwards
        do_reset();
        run_len(1'b0, n);
        chk("hb_low1", 32'(n), 50);
        repeat (10) step();
        chk("hb_high_mid", 32'(led), 1);
        req  = 4'b0010;
        code = 16'h0010;
        step();
        chk("hb_grant", 32'(grant), 4'b0010);
        chk("hb_grant_led", 32'(led), 1);
        req = 4'b0000;
        collect(tot, nr, runs);
        chk("hb_seq_total", 32'(tot), 120);
        chk("hb_seq_on", 32'(runs[0]), 20);
        chk("hb_seq_gap", 32'(runs[1]), 100);
        chk("hb_done", 32'(done), 1);
        run_len(1'b0, n);
        chk("hb_restart_low", 32'(n), 50);
        run_len(1'b1, n);
        chk("hb_restart_high", 32'(n), 50);
`else
        // Without heartbeat the LED stays dark while idle
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (led !== 1'b0) n++;
            step();
        end
        chk("idle_led_dark", 32'(n), 0);
`endif

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
